ofmap_deskew_collector: RTL and testbench

Reader-side companion to the systolic array's ofmap outputs. Column c of the array's ofmap bus carries a given output row c enable-cycles after column 0. This block re-aligns those staggered partial-sum columns into complete row vectors, buffers them in a small FIFO, and presents them on a ready/valid interface to the ofmap writeback path. It also gives the array controller a space indication so that enable can be throttled before the buffer overflows.

---
 rtl/ofmap_deskew_collector_if.sv | 13 +
 rtl/ofmap_deskew_collector.sv | 121 ++++++++++++
 tb/tb_ofmap_deskew_collector.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ofmap_deskew_collector_if.sv
// Row-vector stream from the deskew collector to the ofmap writeback path.
// master drives row_data/row_valid, slave returns row_ready.
interface ofmap_deskew_collector_if #(
  parameter int unsigned OFMAP_WIDTH = 32,
  parameter int unsigned ARRAY_WIDTH = 4
);
  logic [OFMAP_WIDTH-1:0] row_data [ARRAY_WIDTH-1:0];
  logic                   row_valid;
  logic                   row_ready;

  modport master (output row_data, output row_valid, input row_ready);
  modport slave  (input row_data, input row_valid, output row_ready);
endinterface

// File: rtl/ofmap_deskew_collector.sv
// Re-aligns the staggered ofmap columns of the systolic array into full row vectors,
// buffers them in a show-ahead FIFO and reports buffer space to the array controller.
module ofmap_deskew_collector #(
  parameter int unsigned OFMAP_WIDTH = 32,
  parameter int unsigned ARRAY_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH  = 8,
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   col0_valid,
  input  logic [OFMAP_WIDTH-1:0] array_ofmap [ARRAY_WIDTH-1:0],
  ofmap_deskew_collector_if.master row_if,
  output logic                   space_ok,
  output logic [CntW-1:0]        count,
  output logic                   overflow_err
);

  localparam int unsigned Lag  = ARRAY_WIDTH - 1;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  typedef logic [ARRAY_WIDTH-1:0][OFMAP_WIDTH-1:0] row_t;

  row_t aligned;

  // Column c waits Lag-c enable cycles so every column lines up with the live last column.
  for (genvar c = 0; c < int'(Lag); c++) begin : g_dly
    localparam int unsigned Stages = Lag - c;
    logic [OFMAP_WIDTH-1:0] sr_d [Stages];
    logic [OFMAP_WIDTH-1:0] sr_q [Stages];

    always_comb begin
      sr_d = sr_q;
      if (enable) begin
        sr_d[0] = array_ofmap[c];
        for (int s = 1; s < int'(Stages); s++) sr_d[s] = sr_q[s-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < int'(Stages); s++) sr_q[s] <= '0;
      end else begin
        sr_q <= sr_d;
      end
    end

    assign aligned[c] = sr_q[Stages-1];
  end
  assign aligned[ARRAY_WIDTH-1] = array_ofmap[ARRAY_WIDTH-1];

  logic [Lag-1:0]  tok_d, tok_q;
  logic [CntW:0]   tok_cnt;
  row_t            mem_d [FIFO_DEPTH];
  row_t            mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CntW-1:0] count_d, count_q;
  logic            ovf_d, ovf_q;
  logic            complete, full, push, pop;

  always_comb begin
    tok_d = tok_q;
    if (enable) begin
      tok_d[0] = col0_valid;
      for (int i = 1; i < int'(Lag); i++) tok_d[i] = tok_q[i-1];
    end
    tok_cnt = '0;
    for (int i = 0; i < int'(Lag); i++) tok_cnt = tok_cnt + (CntW+1)'(tok_q[i]);
  end

  assign complete = enable & tok_q[Lag-1];
  assign full     = (count_q == CntW'(FIFO_DEPTH));
  assign pop      = (count_q != '0) & row_if.row_ready;
  // A push into a full buffer is only safe when the head leaves on the same edge.
  assign push     = complete & (~full | pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (complete & full & ~pop);
    if (push) begin
      mem_d[wr_ptr_q] = aligned;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop) count_d = count_q + CntW'(1);
    else if (pop && !push) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      tok_q    <= tok_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      mem_q    <= mem_d;
    end
  end

  always_comb begin
    for (int c = 0; c < int'(ARRAY_WIDTH); c++) row_if.row_data[c] = mem_q[rd_ptr_q][c];
  end

  assign row_if.row_valid = (count_q != '0);
  assign count            = count_q;
  assign overflow_err     = ovf_q;
  // Rows already in the token line will land in the FIFO regardless of enable.
  assign space_ok = (({1'b0, count_q} + tok_cnt) <= (CntW+1)'(FIFO_DEPTH - 1));

endmodule

// File: tb/tb_ofmap_deskew_collector.sv
// Directed bench for ofmap_deskew_collector (W=4, depth 8) with hand-computed row values.
module tb_ofmap_deskew_collector;
  localparam int unsigned OW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned FD = 8;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        col0_valid;
  logic [31:0] ofmap [AW-1:0];
  logic        space_ok;
  logic [3:0]  count;
  logic        overflow_err;
  logic [127:0] got_row;

  int checks = 0;
  int errors = 0;

  ofmap_deskew_collector_if #(.OFMAP_WIDTH(OW), .ARRAY_WIDTH(AW)) rif ();

  ofmap_deskew_collector #(
    .OFMAP_WIDTH(OW),
    .ARRAY_WIDTH(AW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .col0_valid  (col0_valid),
    .array_ofmap (ofmap),
    .row_if      (rif.master),
    .space_ok    (space_ok),
    .count       (count),
    .overflow_err(overflow_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    for (int c = 0; c < 4; c++) got_row[c*32 +: 32] = rif.row_data[c];
  end

  function automatic logic [127:0] exp_row(input int r);
    logic [127:0] e;
    for (int c = 0; c < 4; c++) e[c*32 +: 32] = 32'(r * 10 + c);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bus();
    col0_valid = 1'b0;
    for (int c = 0; c < 4; c++) ofmap[c] = '0;
  endtask

  // Staggered stream of n rows starting at cycle 0: column c carries row t-c.
  task automatic drive_cycle(input int t, input int n);
    col0_valid = (t < n);
    for (int c = 0; c < 4; c++) begin
      ofmap[c] = ((t - c) >= 0 && (t - c) < n) ? 32'((t - c) * 10 + c) : 32'd0;
    end
  endtask

  initial begin
    rst_n      = 1'b1;
    enable     = 1'b0;
    rif.row_ready = 1'b0;
    clear_bus();

    // 1: reset
    #2 rst_n = 1'b0;
    #3;
    chk("rst_row_valid", 128'(rif.row_valid), 128'd0);
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_space_ok", 128'(space_ok), 128'd1);
    chk("rst_overflow", 128'(overflow_err), 128'd0);
    chk("rst_row_data", got_row, 128'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rel_row_valid", 128'(rif.row_valid), 128'd0);
    chk("rel_count", 128'(count), 128'd0);
    tick();

    // 2: single row 10..13
    enable = 1'b1;
    rif.row_ready = 1'b1;
    col0_valid = 1'b1; ofmap[0] = 32'd10;
    tick();
    col0_valid = 1'b0; ofmap[0] = 32'd0; ofmap[1] = 32'd11;
    tick();
    ofmap[1] = 32'd0; ofmap[2] = 32'd12;
    tick();
    ofmap[2] = 32'd0; ofmap[3] = 32'd13;
    chk("single_early_valid", 128'(rif.row_valid), 128'd0);
    tick();
    clear_bus();
    chk("single_valid", 128'(rif.row_valid), 128'd1);
    chk("single_data", got_row, exp_row(1));
    tick();
    chk("single_valid_once", 128'(rif.row_valid), 128'd0);
    chk("single_count", 128'(count), 128'd0);

    // 3: enable gap t2..t4 with bus held
    col0_valid = 1'b1; ofmap[0] = 32'd10;
    tick();
    col0_valid = 1'b0; ofmap[0] = 32'd0; ofmap[1] = 32'd11;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_no_row", 128'(rif.row_valid), 128'd0);
    end
    enable = 1'b1; ofmap[1] = 32'd0; ofmap[2] = 32'd12;
    tick();
    chk("gap_no_row_t6", 128'(rif.row_valid), 128'd0);
    ofmap[2] = 32'd0; ofmap[3] = 32'd13;
    tick();
    clear_bus();
    chk("gap_valid", 128'(rif.row_valid), 128'd1);
    chk("gap_data", got_row, exp_row(1));
    tick();
    chk("gap_drained", 128'(count), 128'd0);

    // 4: backpressure, 8 rows
    rif.row_ready = 1'b0;
    for (int t = 0; t <= 10; t++) begin
      drive_cycle(t, 8);
      tick();
      if (t == 6) chk("bp_space_ok_7", 128'(space_ok), 128'd1);
      if (t == 7) chk("bp_space_ok_8", 128'(space_ok), 128'd0);
    end
    clear_bus();
    chk("bp_count_full", 128'(count), 128'd8);
    chk("bp_overflow", 128'(overflow_err), 128'd0);
    rif.row_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      chk("bp_valid", 128'(rif.row_valid), 128'd1);
      chk($sformatf("bp_row%0d", r), got_row, exp_row(r));
      tick();
    end
    chk("bp_empty", 128'(rif.row_valid), 128'd0);
    chk("bp_space_back", 128'(space_ok), 128'd1);

    // 5a: overflow, 9th row dropped
    rif.row_ready = 1'b0;
    for (int t = 0; t <= 11; t++) begin
      drive_cycle(t, 9);
      tick();
      if (t == 10) chk("ovf_before", 128'(overflow_err), 128'd0);
    end
    clear_bus();
    chk("ovf_set", 128'(overflow_err), 128'd1);
    chk("ovf_count", 128'(count), 128'd8);
    rif.row_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      chk($sformatf("ovf_row%0d", r), got_row, exp_row(r));
      tick();
    end
    chk("ovf_9th_absent", 128'(rif.row_valid), 128'd0);
    chk("ovf_sticky", 128'(overflow_err), 128'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("ovf_cleared", 128'(overflow_err), 128'd0);

    // 5b: pop in the 9th completion cycle rescues the push
    for (int t = 0; t <= 11; t++) begin
      drive_cycle(t, 9);
      rif.row_ready = (t == 11);
      tick();
    end
    rif.row_ready = 1'b0;
    clear_bus();
    chk("rescue_no_ovf", 128'(overflow_err), 128'd0);
    chk("rescue_count", 128'(count), 128'd8);
    rif.row_ready = 1'b1;
    for (int r = 1; r < 9; r++) begin
      chk($sformatf("rescue_row%0d", r), got_row, exp_row(r));
      tick();
    end
    chk("rescue_empty", 128'(rif.row_valid), 128'd0);

    // 6: reset with 2 buffered and 2 in flight
    rif.row_ready = 1'b0;
    for (int t = 0; t <= 4; t++) begin
      drive_cycle(t, 4);
      tick();
    end
    chk("mid_count_pre", 128'(count), 128'd2);
    clear_bus();
    rst_n = 1'b0;
    #1;
    chk("mid_async_count", 128'(count), 128'd0);
    chk("mid_async_valid", 128'(rif.row_valid), 128'd0);
    chk("mid_async_space", 128'(space_ok), 128'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rif.row_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_no_ghost", 128'(rif.row_valid), 128'd0);
    end
    col0_valid = 1'b1; ofmap[0] = 32'd10;
    tick();
    col0_valid = 1'b0; ofmap[0] = 32'd0; ofmap[1] = 32'd11;
    tick();
    ofmap[1] = 32'd0; ofmap[2] = 32'd12;
    tick();
    ofmap[2] = 32'd0; ofmap[3] = 32'd13;
    tick();
    clear_bus();
    chk("mid_fresh_valid", 128'(rif.row_valid), 128'd1);
    chk("mid_fresh_data", got_row, exp_row(1));
    tick();
    chk("mid_fresh_count", 128'(count), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
